// File: rtl/ntt_defines_pkg.sv
// Shared constants and bundle types for the masked
// Barrett conditional-subtract datapath and its scheduler.
package ntt_defines_pkg;

  localparam int MLKEM_Q = 3329;
  localparam int MLKEM_Q_WIDTH = 12;
  localparam int IFCOND_C_W = 14;
  localparam int MASKED_IFCOND_RND_W = 55;

  typedef struct packed {
    logic        rnd_1bit;
    logic [13:0] rnd_bool1;
    logic [13:0] rnd_bool0;
    logic [13:0] rnd_14bit;
    logic [11:0] rnd_12bit;
  } masked_ifcond_rnd_t;

  typedef logic [1:0][MLKEM_Q_WIDTH-1:0] arith_pair_t;
  typedef logic [1:0][IFCOND_C_W-1:0] c_pair_t;

  function automatic logic [MLKEM_Q_WIDTH-1:0] q_or_zero(
    input logic sel
  );
    return sel ? MLKEM_Q_WIDTH'(MLKEM_Q) : '0;
  endfunction

endpackage

// File: rtl/masked_barrett_if_cond_v2.sv
// Three-stage masked datapath: remask, extract the bit-12 condition
// into Boolean shares, then convert q*cond into arithmetic shares.
module masked_barrett_if_cond_v2
  import ntt_defines_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           zeroize,
  input  logic [1:0][IFCOND_C_W-1:0]     c_rolled,
  input  logic [MASKED_IFCOND_RND_W-1:0] rnd,
  output logic [1:0][MLKEM_Q_WIDTH-1:0]  arith_q
);

  masked_ifcond_rnd_t r;
  logic [IFCOND_C_W-1:0] mask14;

  logic [1:0][12:0] a_q;
  logic             b_rnd_q;
  logic [11:0]      m1_q;

  logic [12:0]      sum13;
  logic             cond;
  logic [1:0]       b_q;
  logic [11:0]      m2_q;

  logic [MLKEM_Q_WIDTH-1:0] qv;

  assign r      = rnd;
  assign mask14 = r.rnd_14bit ^ r.rnd_bool0 ^ r.rnd_bool1;

  // only bits 12:0 of the share sum matter for the condition
  assign sum13 = a_q[0] + a_q[1];
  assign cond  = sum13 >= 13'h1000;
  assign qv    = q_or_zero(b_q[0] ^ b_q[1]);

  always_ff @(posedge clk) begin
    if (!rst_n || zeroize) begin
      a_q     <= '0;
      b_rnd_q <= 1'b0;
      m1_q    <= '0;
      b_q     <= '0;
      m2_q    <= '0;
      arith_q <= '0;
    end else begin
      a_q[0]  <= 13'(c_rolled[0] + mask14);
      a_q[1]  <= 13'(c_rolled[1] - mask14);
      b_rnd_q <= r.rnd_1bit;
      m1_q    <= r.rnd_12bit;

      b_q[0]  <= b_rnd_q;
      b_q[1]  <= cond ^ b_rnd_q;
      m2_q    <= m1_q;

      arith_q[0] <= m2_q;
      arith_q[1] <= qv - m2_q;
    end
  end

endmodule

// File: rtl/masked_barrett_if_cond_sched.sv
// Credit-based issue controller and output FIFO around the
// non-stallable masked Barrett conditional-subtract datapath.
module masked_barrett_if_cond_sched
  import ntt_defines_pkg::*;
#(
  parameter int OUT_DEPTH = 4,
  parameter int DP_LAT    = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           zeroize,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1:0][IFCOND_C_W-1:0]     c_rolled_i,
  input  logic                           rnd_valid,
  output logic                           rnd_ready,
  input  logic [MASKED_IFCOND_RND_W-1:0] rnd_i,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [1:0][MLKEM_Q_WIDTH-1:0]  arith_q_o,
  output logic                           busy
);

  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int OW = $clog2(OUT_DEPTH + DP_LAT + 1);

  logic [DP_LAT-1:0] v;
  logic [CW-1:0]     fifo_cnt;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  arith_pair_t       mem [OUT_DEPTH];

  logic [MASKED_IFCOND_RND_W-1:0] rnd_hold;
  logic [MASKED_IFCOND_RND_W-1:0] dp_rnd;
  c_pair_t                        dp_c;
  arith_pair_t                    dp_q;

  logic          flush;
  logic          issue;
  logic          credit_ok;
  logic          push;
  logic          pop;
  logic [OW-1:0] occ;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign flush = !rst_n || zeroize;

  // slots already claimed: buffered plus in flight, minus this pop
  always_comb begin
    occ = OW'(fifo_cnt);
    for (int i = 0; i < DP_LAT; i++) begin
      occ = occ + OW'(v[i]);
    end
    occ = occ - OW'(pop);
  end

  assign credit_ok = occ < OW'(OUT_DEPTH);
  assign issue     = in_valid & rnd_valid & credit_ok & ~flush;
  assign in_ready  = issue;
  assign rnd_ready = issue;

  assign push = v[DP_LAT-1];
  assign pop  = out_valid & out_ready;

  assign dp_c   = issue ? c_rolled_i : '0;
  assign dp_rnd = issue ? rnd_i : rnd_hold;

  masked_barrett_if_cond_v2 u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .zeroize  (zeroize),
    .c_rolled (dp_c),
    .rnd      (dp_rnd),
    .arith_q  (dp_q)
  );

  always_ff @(posedge clk) begin
    if (flush) begin
      v        <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      rnd_hold <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      v <= {v[DP_LAT-2:0], issue};
      if (issue) begin
        rnd_hold <= rnd_i;
      end
      if (push) begin
        mem[wr_ptr] <= dp_q;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      unique case (1'b1)
        push && !pop: fifo_cnt <= fifo_cnt + CW'(1);
        pop && !push: fifo_cnt <= fifo_cnt - CW'(1);
        default:      fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign out_valid = fifo_cnt != '0;
  assign arith_q_o = mem[rd_ptr];
  assign busy      = (|v) | out_valid;

  a_no_overflow: assert property (
    @(posedge clk) disable iff (flush)
    !(push && !pop && fifo_cnt == CW'(OUT_DEPTH))
  );

endmodule
